// File: rtl/deck_shuffle_writer_if.sv
// Card-memory write port plus game-control handshake for deck_shuffle_writer.
// master: game controller side; slave: the deck writer.
interface deck_shuffle_writer_if;
    logic        start;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_data;

    modport master (
        output start, seed_load, seed,
        input  busy, done, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, seed_load, seed,
        output busy, done, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/deck_shuffle_writer.sv
// Builds a deck of card ranks, optionally shuffles it with an LFSR-driven Fisher-Yates,
// and streams it into card memory. Shuffle is compiled in with `DECK_SHUFFLE_EN.
module deck_shuffle_writer #(
    parameter int unsigned DECK_SIZE    = 52,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    deck_shuffle_writer_if.slave bus
);
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 4;
    localparam int unsigned LW    = 16;
    localparam int unsigned RANKS = 13;
    localparam logic [LW-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DECK_SIZE - 1);

`ifdef DECK_SHUFFLE_EN
    typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, INIT, WRITE} state_t;
`endif

    state_t          state_q;
    logic [DW-1:0]   deck_q [DECK_SIZE];
    logic [LW-1:0]   lfsr_q;
    logic            busy_q;
    logic            done_q;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q;
    logic [LW-1:0]   seed_val_c;
    logic [LW-1:0]   lfsr_idle_c;

    // Galois LFSR, right shift
    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    assign seed_val_c = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;

`ifdef DECK_SHUFFLE_EN
    logic [AW-1:0] i_q;
    logic [AW-1:0] mask_c;
    logic [AW-1:0] cand_c;

    // Smallest all-ones mask covering i, so rejection keeps j uniform over 0..i
    function automatic logic [AW-1:0] cover_mask(input logic [AW-1:0] v);
        logic [AW-1:0] m1;
        logic [AW-1:0] m2;
        m1 = v | (v >> 1);
        m2 = m1 | (m1 >> 2);
        return m2 | (m2 >> 4);
    endfunction

    assign mask_c      = cover_mask(i_q);
    assign cand_c      = lfsr_q[AW-1:0] & mask_c;
    assign lfsr_idle_c = lfsr_step(lfsr_q);
`else
    assign lfsr_idle_c = lfsr_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lfsr_q    <= DEFAULT_SEED;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int k = 0; k < int'(DECK_SIZE); k++) deck_q[k] <= '0;
`ifdef DECK_SHUFFLE_EN
            i_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= INIT;
                        busy_q  <= 1'b1;
                    end
                    // start wins over seed_load
                    lfsr_q <= (bus.seed_load && !bus.start) ? seed_val_c : lfsr_idle_c;
                end
                INIT: begin
                    for (int k = 0; k < int'(DECK_SIZE); k++)
                        deck_q[k] <= DW'((k % int'(RANKS)) + 1);
`ifdef DECK_SHUFFLE_EN
                    i_q     <= LAST_ADDR;
                    state_q <= SHUFFLE;
`else
                    // first card of the ordered deck goes out as INIT completes
                    state_q   <= WRITE;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= '0;
                    wr_data_q <= DW'(1);
`endif
                end
`ifdef DECK_SHUFFLE_EN
                SHUFFLE: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    if (cand_c <= i_q) begin
                        deck_q[i_q]    <= deck_q[cand_c];
                        deck_q[cand_c] <= deck_q[i_q];
                        if (i_q == AW'(1)) begin
                            // last swap is 0<->1 or a no-op; present post-swap card 0
                            state_q   <= WRITE;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= '0;
                            wr_data_q <= (cand_c == '0) ? deck_q[1] : deck_q[0];
                        end else begin
                            i_q <= i_q - AW'(1);
                        end
                    end
                end
`endif
                WRITE: begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        wr_addr_q <= wr_addr_q + AW'(1);
                        wr_data_q <= deck_q[wr_addr_q + AW'(1)];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_deck_shuffle_writer.sv
// Scoreboard bench for deck_shuffle_writer: stimulus predicts each game's writes from a
// reference Fisher-Yates model; a negedge monitor pops and compares.
module tb_deck_shuffle_writer;
    localparam int unsigned DECK_SIZE = 52;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deck_shuffle_writer_if bus ();

    deck_shuffle_writer #(
        .DECK_SIZE   (DECK_SIZE),
        .DEFAULT_SEED(DEF_SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int addr;
        int data;
        int when;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    wr_t         exp_q[$];
    int          done_q[$];
    int          busy_lo = 0;
    int          busy_hi = -1;
    int          rank_cnt[14];
    bit          in_order = 1'b1;
    int          model_deck[DECK_SIZE];
    int          model_steps;
    logic [15:0] model_lf;
    wr_t         mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] eff_seed(input logic [15:0] s);
        return (s == 16'h0) ? DEF_SEED : s;
    endfunction

    function automatic int rank_expect(input int r);
        int n = 0;
        for (int k = 0; k < int'(DECK_SIZE); k++) if ((k % 13) + 1 == r) n++;
        return n;
    endfunction

    // Reference deck: ordered ranks, then (if enabled) Fisher-Yates with masked rejection.
    // lf_before is the LFSR value just before the start edge; that idle edge steps it once.
    task automatic predict(input logic [15:0] lf_before);
        for (int k = 0; k < int'(DECK_SIZE); k++) model_deck[k] = (k % 13) + 1;
        model_steps = 0;
`ifdef DECK_SHUFFLE_EN
        begin
            logic [15:0] l;
            int i, j, m, tmp;
            l = lfsr_next(lf_before);
            i = DECK_SIZE - 1;
            while (i >= 1 && model_steps < 100000) begin
                m = 1;
                while (m < i) m = 2 * m + 1;
                j = int'(l[5:0]) & m;
                l = lfsr_next(l);
                model_steps++;
                if (j <= i) begin
                    tmp = model_deck[i];
                    model_deck[i] = model_deck[j];
                    model_deck[j] = tmp;
                    i--;
                end
            end
            model_lf = l;
        end
`else
        model_lf = lf_before;
`endif
    endtask

    // Monitor: compares every write, done pulse and busy level against the scoreboard
    always @(negedge clk) begin
        if (reset) begin
            check("busy", int'(bus.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", int'(bus.wr_addr), mon_e.addr);
                    check("wr_data", int'(bus.wr_data), mon_e.data);
                    check("wr_cycle", cyc, mon_e.when);
                    if (bus.wr_data >= 4'd1 && bus.wr_data <= 4'd13) rank_cnt[bus.wr_data]++;
                    if (int'(bus.wr_data) != (int'(bus.wr_addr) % 13) + 1) in_order = 1'b0;
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("done_wr_en", int'(bus.wr_en), 0);
                    check("done_busy", int'(bus.busy), 0);
                    check("hold_addr", int'(bus.wr_addr), DECK_SIZE - 1);
                    for (int r = 1; r <= 13; r++) check("rank_count", rank_cnt[r], rank_expect(r));
`ifdef DECK_SHUFFLE_EN
                    check("deck_shuffled", int'(in_order), 0);
`endif
                end
                for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
                in_order = 1'b1;
            end
        end
    end

    // Called in the low phase: loads the seed at the next edge
    task automatic load_seed(input logic [15:0] s);
        bus.seed_load = 1'b1;
        bus.seed      = s;
        @(posedge clk);
        #1 bus.seed_load = 1'b0;
        @(negedge clk);
    endtask

    // Called in the low phase: start is sampled at the next edge, expectations are queued
    task automatic launch(input logic [15:0] lf_before, input bit with_seed,
                          input logic [15:0] other_seed);
        int t;
        wr_t e;
        bus.start = 1'b1;
        if (with_seed) begin
            bus.seed_load = 1'b1;
            bus.seed      = other_seed;
        end
        @(posedge clk);
        #1;
        t = cyc;
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        predict(lf_before);
        for (int a = 0; a < int'(DECK_SIZE); a++) begin
            e.addr = a;
            e.data = model_deck[a];
            e.when = t + 1 + model_steps + a;
            exp_q.push_back(e);
        end
        done_q.push_back(t + 1 + model_steps + DECK_SIZE);
        busy_lo = t;
        busy_hi = t + model_steps + DECK_SIZE;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns in the low phase of the done cycle
    task automatic wait_done();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (done_q.size() == 0) break;
        end
        check("done_timeout", done_q.size(), 0);
        check("leftover_writes", exp_q.size(), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic seeded_game(input logic [15:0] s);
        load_seed(s);
        launch(eff_seed(s), 1'b0, 16'h0);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 16'h0;
        reset         = 1'b0;
        for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_wr_en", int'(bus.wr_en), 0);
        check("reset_wr_addr", int'(bus.wr_addr), 0);
        check("reset_wr_data", int'(bus.wr_data), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Known seed, then the same game again after a reset
        seeded_game(16'h1234);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seeded_game(16'h1234);

        // Zero seed behaves as the default seed
        seeded_game(16'h0000);
        seeded_game(DEF_SEED);

        // Stray starts during shuffle and write are ignored
        load_seed(16'h5A5A);
        launch(eff_seed(16'h5A5A), 1'b0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        pulse_start();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.wr_en) break;
        end
        pulse_start();
        wait_done();

        // Back-to-back: start in the done cycle, LFSR continues from the previous game
        launch(model_lf, 1'b0, 16'h0);
        wait_done();

        // start together with seed_load: seed ignored, old LFSR value used
        load_seed(16'h1111);
        launch(16'h1111, 1'b1, 16'h2222);
        wait_done();

        // Reset mid-write aborts immediately
        load_seed(16'h7777);
        launch(eff_seed(16'h7777), 1'b0, 16'h0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_addr > 6'd20) break;
        end
        #2 reset = 1'b0;
        #1;
        check("abort_wr_en", int'(bus.wr_en), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_wr_addr", int'(bus.wr_addr), 0);
        exp_q.delete();
        done_q.delete();
        busy_lo = 0;
        busy_hi = -1;
        for (int r = 0; r < 14; r++) rank_cnt[r] = 0;
        in_order = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seeded_game(16'h7777);

        // Randomized seeds and idle gaps
        for (int g = 0; g < 6; g++) begin
            logic [15:0] s;
            s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            seeded_game(s);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
